and_or_array: RTL and testbench



---
 rtl/and_or_pkg.sv | 22 ++
 rtl/and_or_term.sv | 14 +
 rtl/and_or_array.sv | 155 +++++++++++++++
 tb/tb_and_or_array.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/and_or_pkg.sv
// Shared constants and helpers for the pipelined AND-OR array:
// default sizes, in_data bit placement and the mask reset value.
package and_or_pkg;

    localparam int NCH_DEF   = 2;
    localparam int NTERM_DEF = 2;
    localparam int NIN_DEF   = 3;
    localparam int CNT_W_DEF = 16;
    localparam int MAX_NIN   = 64;

    // Position of input `inp` of term `term` in channel `ch` inside in_data.
    function automatic int bitIdx(input int ch, input int term, input int inp,
                                  input int nterm, input int nin);
        return (ch * nterm + term) * nin + inp;
    endfunction

    // Masks come out of reset with every input participating.
    function automatic logic [MAX_NIN-1:0] maskResetValue(input int nin);
        return {MAX_NIN{1'b1}} >> (MAX_NIN - nin);
    endfunction

endpackage

// File: rtl/and_or_term.sv
// One masked product term: AND of the inputs whose mask bit is set.
// A term with an all-zero mask is switched off and always yields 0.
module and_or_term #(
    parameter int NIN = 3
) (
    input  logic [NIN-1:0] mask_i,
    input  logic [NIN-1:0] data_i,
    output logic           term_o
);

    // Unmasked inputs are forced to 1 so they drop out of the AND.
    assign term_o = (|mask_i) && (&(data_i | ~mask_i));

endmodule

// File: rtl/and_or_array.sv
// Two-stage valid/ready sum-of-products unit with a programmable mask file.
// Define AND_OR_HIT_CNT_EN to add per-channel saturating hit counters.
module and_or_array
    import and_or_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int NTERM = NTERM_DEF,
`ifdef AND_OR_HIT_CNT_EN
    parameter int CNT_W = CNT_W_DEF,
`endif
    parameter int NIN   = NIN_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_we,
    input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0]     cfg_ch,
    input  logic [(NTERM > 1 ? $clog2(NTERM) : 1)-1:0] cfg_term,
    input  logic [NIN-1:0]                    cfg_mask,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NCH*NTERM*NIN-1:0]          in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NCH-1:0]                    out_y
`ifdef AND_OR_HIT_CNT_EN
    ,
    input  logic                              cnt_clr,
    output logic [NCH*CNT_W-1:0]              hit_cnt
`endif
);

    localparam int NT = NCH * NTERM;
    localparam logic [NIN-1:0] MASK_INIT = NIN'(maskResetValue(NIN));

    logic [NIN-1:0] mask_q [NT];
    logic           cfgHit;
    int             cfgIdx;
    logic [NT-1:0]  termVal;

    logic           s1Valid_q, s1Valid_d;
    logic [NT-1:0]  s1Terms_q, s1Terms_d;
    logic           outValid_q, outValid_d;
    logic [NCH-1:0] outY_q, outY_d;
    logic [NCH-1:0] chanOr;
    logic           s1Ready, s2Ready, inFire;

    always_comb begin
        cfgHit = (int'(cfg_ch) < NCH) && (int'(cfg_term) < NTERM);
        cfgIdx = int'(cfg_ch) * NTERM + int'(cfg_term);
    end

    // Mask file; writes aimed outside the array are dropped.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NT; k++) begin
            if (reset) begin
                mask_q[k] <= MASK_INIT;
            end else if (cfg_we && cfgHit && (k == cfgIdx)) begin
                mask_q[k] <= cfg_mask;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : gCh
        for (genvar t = 0; t < NTERM; t++) begin : gTerm
            localparam int BASE = bitIdx(c, t, 0, NTERM, NIN);
            and_or_term #(.NIN(NIN)) uTerm (
                .mask_i (mask_q[c*NTERM+t]),
                .data_i (in_data[BASE +: NIN]),
                .term_o (termVal[c*NTERM+t])
            );
        end
    end

    assign s2Ready  = !outValid_q || out_ready;
    assign s1Ready  = !s1Valid_q || s2Ready;
    assign in_ready = s1Ready;
    assign inFire   = in_valid && in_ready;

    // Stage 1 samples term values (and hence the mask) at acceptance, so a
    // mask write in the same cycle only affects later beats.
    always_comb begin
        chanOr = '0;
        for (int c = 0; c < NCH; c++) begin
            chanOr[c] = |s1Terms_q[c*NTERM +: NTERM];
        end
        s1Valid_d  = s1Valid_q;
        s1Terms_d  = s1Terms_q;
        outValid_d = outValid_q;
        outY_d     = outY_q;
        if (s1Ready) begin
            s1Valid_d = in_valid;
            if (inFire) begin
                s1Terms_d = termVal;
            end
        end
        if (s2Ready) begin
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                outY_d = chanOr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q  <= 1'b0;
            s1Terms_q  <= '0;
            outValid_q <= 1'b0;
            outY_q     <= '0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Terms_q  <= s1Terms_d;
            outValid_q <= outValid_d;
            outY_q     <= outY_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_y     = outY_q;

`ifdef AND_OR_HIT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic             outFire;

    assign outFire = outValid_q && out_ready;

    // Clear wins over a simultaneous hit; counters stick at all ones.
    always_comb begin
        hit_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (cnt_clr) begin
                cnt_d[c] = '0;
            end else if (outFire && outY_q[c] && (cnt_q[c] != CNT_MAX)) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
            hit_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                cnt_q[c] <= '0;
            end else begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end
`endif

endmodule

// File: tb/tb_and_or_array.sv
// Self-checking bench for and_or_array: vector table, corner sequences and
// randomized streams against a sum-of-products reference model.
module tb_and_or_array;

    localparam int NCH   = 2;
    localparam int NTERM = 2;
    localparam int NIN   = 3;
    localparam int CNT_W = 2;
    localparam int DW    = NCH * NTERM * NIN;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [0:0]    cfg_ch = '0;
    logic [0:0]    cfg_term = '0;
    logic [NIN-1:0] cfg_mask = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NCH-1:0] out_y;
`ifdef AND_OR_HIT_CNT_EN
    logic          cnt_clr = 1'b0;
    logic [NCH*CNT_W-1:0] hit_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [NIN-1:0] mMask [NCH][NTERM];

    typedef struct {
        bit             doCfg;
        int             ch;
        int             term;
        logic [NIN-1:0] mask;
        logic [DW-1:0]  data;
        logic [NCH-1:0] expY;
    } vec_t;

    vec_t tbl [9];

    and_or_array #(
        .NCH   (NCH),
        .NTERM (NTERM),
`ifdef AND_OR_HIT_CNT_EN
        .CNT_W (CNT_W),
`endif
        .NIN   (NIN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_term  (cfg_term),
        .cfg_mask  (cfg_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
`ifdef AND_OR_HIT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .hit_cnt   (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: a channel is 1 when any enabled term sees all its masked inputs high.
    function automatic logic [NCH-1:0] refY(input logic [DW-1:0] d);
        logic [NCH-1:0] y;
        logic [NIN-1:0] x;
        y = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int t = 0; t < NTERM; t++) begin
                x = d[(c*NTERM+t)*NIN +: NIN];
                if (mMask[c][t] != 0 && (x & mMask[c][t]) == mMask[c][t]) y[c] = 1'b1;
            end
        end
        return y;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < NTERM; t++)
                mMask[c][t] = '1;
    endtask

    task automatic cfgWrite(input int ch, input int term, input logic [NIN-1:0] m);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = ch[0:0];
        cfg_term = term[0:0];
        cfg_mask = m;
        @(negedge clk);
        cfg_we = 1'b0;
        mMask[ch][term] = m;
    endtask

    // One isolated beat; checks the two-cycle latency and the result.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic [NCH-1:0] expY, input string name);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({name, ".early"}, out_valid, 0);
        @(negedge clk);
        checkOutput({name, ".valid"}, out_valid, 1);
        checkOutput({name, ".y"}, out_y, expY);
    endtask

    // mode 0: continuous input, out_ready low on cycles 3-5; mode 1: random both sides.
    task automatic runStream(input int n, input int mode, input string name);
        logic [NCH-1:0] q [$];
        logic [NCH-1:0] prevY;
        logic [NCH-1:0] expY;
        logic           prevStall;
        int             sent;
        int             got;
        sent = 0;
        got = 0;
        prevStall = 1'b0;
        prevY = '0;
        for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
            @(negedge clk);
            if (prevStall) begin
                checkOutput({name, ".stallValid"}, out_valid, 1);
                checkOutput({name, ".stallHold"}, out_y, prevY);
            end
            if (q.size() == 0) checkOutput({name, ".idle"}, out_valid, 0);
            in_valid  = (sent < n) && (mode == 0 || $urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = (mode == 0) ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 3) != 0);
            #1;
            checkOutput({name, ".inReady"}, in_ready, (q.size() < 2) || out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s.spurious: got output required none", name);
                end else begin
                    expY = q.pop_front();
                    checkOutput({name, ".y"}, out_y, expY);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(refY(in_data));
                sent++;
            end
            prevStall = out_valid && !out_ready;
            prevY = out_y;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput({name, ".count"}, got, n);
    endtask

    initial begin
        logic [NCH-1:0] e1;
        logic [NCH-1:0] e2;
        // Layout of each data word: {ch1t1, ch1t0, ch0t1, ch0t0}.
        tbl[0] = '{0, 0, 0, 3'b000, 12'b000_000_000_111, 2'b01};
        tbl[1] = '{0, 0, 0, 3'b000, 12'b000_000_110_110, 2'b00};
        tbl[2] = '{0, 0, 0, 3'b000, 12'b111_000_000_000, 2'b10};
        tbl[3] = '{1, 1, 0, 3'b011, 12'b000_000_000_000, 2'b00};
        tbl[4] = '{1, 1, 1, 3'b011, 12'b000_011_000_000, 2'b10};
        tbl[5] = '{0, 0, 0, 3'b000, 12'b001_010_000_000, 2'b00};
        tbl[6] = '{1, 1, 1, 3'b000, 12'b111_000_000_000, 2'b00};
        tbl[7] = '{0, 0, 0, 3'b000, 12'b111_111_000_000, 2'b10};
        tbl[8] = '{0, 0, 0, 3'b000, 12'b111_100_111_111, 2'b01};

        resetModel();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst.inReady", in_ready, 1);
        checkOutput("rst.outValid", out_valid, 0);
        checkOutput("rst.outY", out_y, 0);
`ifdef AND_OR_HIT_CNT_EN
        checkOutput("rst.hitCnt", hit_cnt, 0);
`endif

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].doCfg) cfgWrite(tbl[i].ch, tbl[i].term, tbl[i].mask);
            applyStimulus(tbl[i].data, tbl[i].expY, $sformatf("vec%0d", i));
        end

        // Mask write coinciding with acceptance only affects the following beat.
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_term = 1'b0; cfg_mask = 3'b001;
        in_valid = 1'b1; in_data = 12'b000_000_000_001; out_ready = 1'b1;
        e1 = refY(in_data);
        mMask[0][0] = 3'b001;
        @(negedge clk);
        cfg_we = 1'b0;
        e2 = refY(in_data);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("cfgSame.valid", out_valid, 1);
        checkOutput("cfgSame.oldMask", out_y, 2'b00);
        checkOutput("cfgSame.model1", out_y, e1);
        @(negedge clk);
        checkOutput("cfgNext.valid", out_valid, 1);
        checkOutput("cfgNext.newMask", out_y, 2'b01);
        checkOutput("cfgNext.model2", out_y, e2);

        runStream(8, 0, "stall");

        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < NTERM; t++)
                cfgWrite(c, t, NIN'($urandom));
        runStream(40, 1, "rand");

        // Reset with two beats in flight, after leaving non-default masks.
        cfgWrite(0, 0, 3'b000);
        cfgWrite(1, 0, 3'b001);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 12'b000_000_000_111;
        @(negedge clk);
        in_data = 12'b000_001_000_111;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        resetModel();
        checkOutput("midRst.outValid", out_valid, 0);
        checkOutput("midRst.outY", out_y, 0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("midRst.noOutput", out_valid, 0);
        applyStimulus(12'b000_001_000_111, 2'b01, "midRst.masks");

`ifdef AND_OR_HIT_CNT_EN
        @(negedge clk);
        checkOutput("cnt.afterRst", hit_cnt, 4'b0001);
        for (int i = 0; i < 4; i++) applyStimulus(12'b000_000_000_111, 2'b01, "cnt.beat");
        @(negedge clk);
        checkOutput("cnt.saturate", hit_cnt, 4'b0011);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checkOutput("cnt.clr", hit_cnt, 0);
        applyStimulus(12'b111_000_000_111, 2'b11, "cnt.both1");
        applyStimulus(12'b000_000_000_111, 2'b01, "cnt.ch0");
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checkOutput("cnt.clrWithFire", hit_cnt, 0);
        @(negedge clk);
        checkOutput("cnt.stayZero", hit_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
